local_hist_predictor: RTL and testbench
=======================================

Name: local_hist_predictor

Overview:
- Parametrised two-level local-history branch predictor for the lc3b fetch stage.
- A per-PC branch history table (BHT) of HIST_W-bit shift registers selects an entry in a pattern history table (PHT) of CTR_W-bit saturating counters.
- Generalises the fixed 3-bit-index / 4-bit-history / 2-bit-counter unit in index width, history length and counter width.
- Adds a reset-time PHT initialisation sweep with a ready flag, and defined update/predict collision rules.

Parameters:
- PC_IDX_W, 3, number of PC bits (pc[PC_IDX_W:1]) indexing the BHT; BHT depth = 2^PC_IDX_W.
- HIST_W, 4, local history length; PHT depth = 2^(PC_IDX_W+HIST_W).
- CTR_W, 2, saturating counter width (2..4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pred_pc  in  16  lc3b_word, PC being fetched.
- pred_taken  out  1  prediction for pred_pc, combinational.
- ready  out  1  high once PHT initialisation is complete.
- upd_valid  in  1  resolved branch update strobe.
- upd_pc  in  16  lc3b_word, PC of the resolved branch.
- upd_taken  in  1  actual branch outcome.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state INIT, init_cnt=0, ready=0, all BHT entries=0.
  - pred_taken=0 while in INIT.
  - PHT is not reset asynchronously.
- FSM INIT:
  - Each clk writes PHT[init_cnt] = WNT = 2^(CTR_W-1)-1, then init_cnt++.
  - Write of the last index (2^(PC_IDX_W+HIST_W)-1) moves to RUN; ready=1 from that edge.
  - Default sweep is 128 cycles.
  - upd_valid is ignored in INIT.
- FSM RUN: stays until rst_n is asserted. Reset mid-RUN or mid-INIT restarts the full sweep.
- Prediction (RUN), combinational, zero latency:
  - i = pred_pc[PC_IDX_W:1].
  - pht_ind = {i, BHT[i]}.
  - pred_taken = MSB of PHT[pht_ind].
- Update (RUN, upd_valid=1), single clk edge:
  - u = upd_pc[PC_IDX_W:1].
  - pht_ind = {u, BHT[u]}, using the pre-update history.
  - Counter: +1 if upd_taken, saturating at 2^CTR_W-1; -1 otherwise, saturating at 0.
  - BHT[u] = {BHT[u][HIST_W-2:0], upd_taken}.
- Collision: prediction and update in the same cycle, on the same entries, returns pre-update values. No forwarding. The updated value is visible the next cycle.
- Back-to-back updates to the same u every cycle must each use the history written by the previous update.
- All arithmetic is unsigned. Index widths are exact; no wrap except the BHT shift discarding the oldest bit.

Optional Feature:
- Macro: LHP_GSHARE_EN.
- Defined:
  - Adds a global history register ghr of width PC_IDX_W+HIST_W. It is reset to 0 and shifted left with upd_taken on every accepted update.
  - Both predict and update use pht_ind = {i, BHT[i]} XOR ghr.
  - The update uses ghr before its own shift.
- Undefined: no ghr, plain concatenated index as above.

Decomposition:
- Package lc3b_types supplies:
  - typedefs lc3b_bht_ind, lc3b_bht_out, lc3b_pht_ind, sized from shared localparams;
  - the lhp_state_t enum (INIT, RUN);
  - the WNT init constant.
- One sub-module, sat_counter_next: a combinational next-value function of width CTR_W, inputs cur and taken.
- BHT and PHT arrays live in the top module, so INIT and update share the PHT write port through a mux selected by state.

Test Plan (default parameters unless stated):
- Reset sweep: release rst_n. ready=0 and pred_taken=0 for cycles 0..127; ready=1 at edge 128. Any pred_pc then gives pred_taken=0 (counters=1).
- Learning (pc 0x0004, u=2):
  - 4 taken updates: BHT[2]=4'b1111.
  - 2 more taken updates: PHT[{2,1111}] 1->2->3, and pred_pc=0x0004 gives pred_taken=1.
  - A 3rd further taken update saturates at 3.
- Saturation low: pc 0x0006, 3 not-taken updates. PHT[{3,0000}] goes 1->0->0->0, BHT[3]=0, pred_taken=0.
- Collision: in the same cycle as the second taken update of the learning sequence (the one taking the counter 2->3), pred_pc=0x0004 returns the pre-update value. The following cycle returns the updated counter.
- Mid-operation reset: pulse rst_n low while in RUN after training.
  - ready drops immediately; BHT is zero.
  - A new 128-cycle sweep runs, then all predictions are 0.
  - An upd_valid during the sweep has no effect.
- With LHP_GSHARE_EN:
  - 1 taken update at pc 0x0002 gives ghr=7'b0000001.
  - A following update at pc 0x0004 modifies PHT[{2,0000} ^ 7'b0000001] = index 0x21, not 0x20.

Source files
------------

// File: rtl/local_hist_predictor_pkg.sv
// Shared types and constants for the lc3b local-history branch predictor.
// Default widths: 3-bit PC index, 4-bit history, 2-bit counters.
package lc3b_types;

   localparam int LHP_PC_IDX_W  = 3;
   localparam int LHP_HIST_W    = 4;
   localparam int LHP_CTR_W     = 2;
   localparam int LHP_PHT_IND_W = LHP_PC_IDX_W + LHP_HIST_W;

   typedef logic [15:0]              lc3b_word;
   typedef logic [LHP_PC_IDX_W-1:0]  lc3b_bht_ind;
   typedef logic [LHP_HIST_W-1:0]    lc3b_bht_out;
   typedef logic [LHP_PHT_IND_W-1:0] lc3b_pht_ind;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } lhp_state_t;

   // Weakly-not-taken: the largest counter value whose MSB is still 0.
   function automatic int wnt_value(input int ctr_w);
      return (1 << (ctr_w - 1)) - 1;
   endfunction

   localparam logic [LHP_CTR_W-1:0] WNT = LHP_CTR_W'(wnt_value(LHP_CTR_W));

endpackage

// File: rtl/local_hist_predictor_sat_counter_next.sv
// Next value of a CTR_W-bit saturating up/down branch counter.
module sat_counter_next #(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] cur,
   input  logic             taken,
   output logic [CTR_W-1:0] nxt
);

   always_comb begin
      nxt = cur;
      if (taken) begin
         if (cur != {CTR_W{1'b1}}) nxt = cur + CTR_W'(1);
      end else begin
         if (cur != {CTR_W{1'b0}}) nxt = cur - CTR_W'(1);
      end
   end

endmodule

// File: rtl/local_hist_predictor.sv
// Two-level local-history branch predictor (per-PC BHT -> PHT of saturating counters).
// Optional gshare-style index hashing with a global history register: LHP_GSHARE_EN.
module local_hist_predictor
   import lc3b_types::*;
#(
   parameter int PC_IDX_W = LHP_PC_IDX_W,
   parameter int HIST_W   = LHP_HIST_W,
   parameter int CTR_W    = LHP_CTR_W
) (
   input  logic     clk,
   input  logic     rst_n,
   input  lc3b_word pred_pc,
   output logic     pred_taken,
   output logic     ready,
   input  logic     upd_valid,
   input  lc3b_word upd_pc,
   input  logic     upd_taken
);

   localparam int PHT_IND_W = PC_IDX_W + HIST_W;
   localparam int BHT_DEPTH = 1 << PC_IDX_W;
   localparam int PHT_DEPTH = 1 << PHT_IND_W;
   localparam logic [CTR_W-1:0]     CTR_INIT = CTR_W'(wnt_value(CTR_W));
   localparam logic [PHT_IND_W-1:0] LAST_IND = {PHT_IND_W{1'b1}};

   lhp_state_t state_q, state_d;
   logic [PHT_IND_W-1:0] init_cnt;

   logic [HIST_W-1:0] bht [BHT_DEPTH];
   logic [CTR_W-1:0]  pht [PHT_DEPTH];

   logic [PC_IDX_W-1:0]  pred_i, upd_i;
   logic [PHT_IND_W-1:0] pred_ind, upd_ind, ghr_mask;
   logic [CTR_W-1:0]     ctr_next;
   logic                 upd_en;

   logic                 pht_we;
   logic [PHT_IND_W-1:0] pht_wa;
   logic [CTR_W-1:0]     pht_wd;

   // FSM: INIT sweeps the PHT once, RUN persists until the next reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= INIT;
         init_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == INIT) init_cnt <= init_cnt + PHT_IND_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:    if (init_cnt == LAST_IND) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   assign ready  = (state_q == RUN);
   assign upd_en = ready & upd_valid;

`ifdef LHP_GSHARE_EN
   logic [PHT_IND_W-1:0] ghr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ghr <= '0;
      else if (upd_en) ghr <= {ghr[PHT_IND_W-2:0], upd_taken};
   end

   assign ghr_mask = ghr;
`else
   assign ghr_mask = '0;
`endif

   assign pred_i   = pred_pc[PC_IDX_W:1];
   assign upd_i    = upd_pc[PC_IDX_W:1];
   assign pred_ind = {pred_i, bht[pred_i]} ^ ghr_mask;
   assign upd_ind  = {upd_i, bht[upd_i]} ^ ghr_mask;

   // PHT contents are undefined until the sweep completes, so gate on ready.
   assign pred_taken = ready & pht[pred_ind][CTR_W-1];

   sat_counter_next #(.CTR_W(CTR_W)) u_ctr_next (
      .cur   (pht[upd_ind]),
      .taken (upd_taken),
      .nxt   (ctr_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < BHT_DEPTH; k++) bht[k] <= '0;
      end else if (upd_en) begin
         bht[upd_i] <= {bht[upd_i][HIST_W-2:0], upd_taken};
      end
   end

   // Single PHT write port shared between the init sweep and branch updates.
   always_comb begin
      pht_we = 1'b0;
      pht_wa = init_cnt;
      pht_wd = CTR_INIT;
      case (state_q)
         INIT: pht_we = 1'b1;
         RUN: begin
            pht_we = upd_valid;
            pht_wa = upd_ind;
            pht_wd = ctr_next;
         end
         default: pht_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (pht_we) pht[pht_wa] <= pht_wd;
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[15:PC_IDX_W+1], pred_pc[0],
                             upd_pc[15:PC_IDX_W+1], upd_pc[0]};

endmodule

// File: tb/tb_local_hist_predictor.sv
// Self-checking bench for local_hist_predictor (default parameters, either LHP_GSHARE_EN build).
module tb_local_hist_predictor;
   import lc3b_types::*;

   localparam bit GSHARE =
`ifdef LHP_GSHARE_EN
      1'b1;
`else
      1'b0;
`endif

   logic     clk = 1'b0;
   logic     rst_n;
   lc3b_word pred_pc;
   logic     pred_taken;
   logic     ready;
   logic     upd_valid;
   lc3b_word upd_pc;
   logic     upd_taken;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic exp_q[$];
   logic mdl_exp;

   typedef struct packed {
      logic     uv;
      lc3b_word upc;
      logic     ut;
      lc3b_word ppc;
      logic     exp;
   } step_t;

   step_t steps[$];

   // Reference model state
   lc3b_bht_out bht_m [8];
   logic [1:0]  pht_m [128];
   lc3b_pht_ind ghr_m;
   logic        model_run;

   always #5 clk = ~clk;

   local_hist_predictor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pred_pc    (pred_pc),
      .pred_taken (pred_taken),
      .ready      (ready),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken)
   );

   function automatic step_t st(input logic uv, input lc3b_word upc, input logic ut,
                                input lc3b_word ppc, input logic e);
      step_t s;
      s.uv = uv; s.upc = upc; s.ut = ut; s.ppc = ppc; s.exp = e;
      return s;
   endfunction

   function automatic lc3b_pht_ind model_idx(input lc3b_word pc);
      lc3b_bht_ind i;
      i = pc[3:1];
      return {i, bht_m[i]} ^ (GSHARE ? ghr_m : 7'd0);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 8; k++) bht_m[k] = '0;
      for (int k = 0; k < 128; k++) pht_m[k] = 2'd1;
      ghr_m     = '0;
      model_run = 1'b0;
   endtask

   task automatic model_update(input lc3b_word pc, input logic t);
      lc3b_pht_ind ind;
      lc3b_bht_ind i;
      ind = model_idx(pc);
      i   = pc[3:1];
      if (t && pht_m[ind] != 2'd3)       pht_m[ind] = pht_m[ind] + 2'd1;
      else if (!t && pht_m[ind] != 2'd0) pht_m[ind] = pht_m[ind] - 2'd1;
      bht_m[i] = {bht_m[i][2:0], t};
      ghr_m    = {ghr_m[5:0], t};
   endtask

   // Driver: applies one cycle of inputs after the edge, computes the model's
   // pre-update prediction, then advances the model.
   task automatic drive(input logic uv, input lc3b_word upc, input logic ut, input lc3b_word ppc);
      @(posedge clk); #1;
      upd_valid = uv; upd_pc = upc; upd_taken = ut; pred_pc = ppc;
      mdl_exp = model_run ? pht_m[model_idx(ppc)][1] : 1'b0;
      if (uv && model_run) model_update(upc, ut);
   endtask

   task automatic sweep_check(input string name, input logic with_upd);
      for (int c = 0; c < 128; c++) begin
         @(negedge clk);
         chk_cnt++;
         if (ready !== 1'b0 || pred_taken !== 1'b0)
            $display("FAIL %s sweep cycle %0d: ready=%b pred_taken=%b expected 0/0",
                     name, c, ready, pred_taken);
         else pass_cnt++;
         @(posedge clk); #1;
         pred_pc   = 16'($urandom);
         upd_valid = with_upd;
         upd_pc    = 16'h0004;
         upd_taken = 1'b1;
      end
      upd_valid = 1'b0;
      chk_cnt++;
      if (ready !== 1'b1) $display("FAIL %s ready after 128 edges: ready=%b expected 1", name, ready);
      else pass_cnt++;
      model_run = 1'b1;
   endtask

   task automatic test_reset();
      logic e;
      rst_n = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
      pred_pc = 16'($urandom);
      model_reset();
      #1;
      chk_cnt++;
      if (ready !== 1'b0 || pred_taken !== 1'b0)
         $display("FAIL reset outputs: ready=%b pred_taken=%b expected 0/0", ready, pred_taken);
      else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sweep_check("reset", 1'b0);
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, '0, 1'b0, {12'($urandom), 3'(k), 1'($urandom)});
         exp_q.push_back(1'b0);
         @(negedge clk);
         e = exp_q.pop_front();
         chk_cnt++;
         if (pred_taken !== e) $display("FAIL reset_pred[%0d]: pred_taken=%b expected %b", k, pred_taken, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_learning();
      logic e;
      // Steps 5/6 are same-cycle predict+update of PHT[{2,1111}]: pre-update values.
      steps = '{st(1, 16'h4, 1, 16'h4, 0), st(1, 16'h4, 1, 16'h4, 0),
                st(1, 16'h4, 1, 16'h4, 0), st(1, 16'h4, 1, 16'h4, 0),
                st(1, 16'h4, 1, 16'h4, 0), st(1, 16'h4, 1, 16'h4, 1),
                st(0, 16'h0, 0, 16'h4, 1), st(1, 16'h4, 1, 16'h4, 1),
                st(1, 16'h4, 0, 16'h4, 1), st(0, 16'h0, 0, 16'h4, 0)};
      foreach (steps[k]) begin
         drive(steps[k].uv, steps[k].upc, steps[k].ut, steps[k].ppc);
         exp_q.push_back(GSHARE ? mdl_exp : steps[k].exp);
         @(negedge clk);
         e = exp_q.pop_front();
         chk_cnt++;
         if (pred_taken !== e) $display("FAIL learning[%0d]: pred_taken=%b expected %b", k, pred_taken, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_sat_low();
      logic e;
      steps = '{st(1, 16'h6, 0, 16'h6, 0), st(1, 16'h6, 0, 16'h6, 0),
                st(1, 16'h6, 0, 16'h6, 0), st(0, 16'h0, 0, 16'h6, 0),
                st(1, 16'h6, 1, 16'h6, 0), st(0, 16'h0, 0, 16'h6, 0)};
      foreach (steps[k]) begin
         drive(steps[k].uv, steps[k].upc, steps[k].ut, steps[k].ppc);
         exp_q.push_back(GSHARE ? mdl_exp : steps[k].exp);
         @(negedge clk);
         e = exp_q.pop_front();
         chk_cnt++;
         if (pred_taken !== e) $display("FAIL sat_low[%0d]: pred_taken=%b expected %b", k, pred_taken, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      logic e;
      lc3b_word upc;
      for (int k = 0; k < 300; k++) begin
         upc = {12'($urandom), 3'($urandom_range(0, 7)), 1'($urandom)};
         drive(1'($urandom_range(0, 3) != 0), upc, 1'($urandom_range(0, 2) != 0),
               ($urandom_range(0, 1) == 1) ? upc : 16'($urandom));
         exp_q.push_back(mdl_exp);
         @(negedge clk);
         e = exp_q.pop_front();
         chk_cnt++;
         if (pred_taken !== e) $display("FAIL back_to_back[%0d]: pred_taken=%b expected %b", k, pred_taken, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_mid_reset();
      logic e;
      @(posedge clk); #1;
      pred_pc = 16'h0004; upd_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_cnt++;
      if (ready !== 1'b0 || pred_taken !== 1'b0)
         $display("FAIL mid_reset drop: ready=%b pred_taken=%b expected 0/0", ready, pred_taken);
      else pass_cnt++;
      #2 rst_n = 1'b1;
      sweep_check("mid_reset", 1'b1);
      // Only a zeroed BHT[2] lands the final prediction back on the taken-trained entry.
      steps = '{st(1, 16'h4, 1, 16'h4, 0), st(1, 16'h4, 0, 16'h4, 0),
                st(1, 16'h4, 0, 16'h4, 0), st(1, 16'h4, 0, 16'h4, 0),
                st(1, 16'h4, 0, 16'h4, 0), st(0, 16'h0, 0, 16'h4, 1)};
      foreach (steps[k]) begin
         drive(steps[k].uv, steps[k].upc, steps[k].ut, steps[k].ppc);
         exp_q.push_back(GSHARE ? mdl_exp : steps[k].exp);
         @(negedge clk);
         e = exp_q.pop_front();
         chk_cnt++;
         if (pred_taken !== e) $display("FAIL mid_reset[%0d]: pred_taken=%b expected %b", k, pred_taken, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_gshare();
      logic e;
      @(posedge clk); #1;
      upd_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #2 rst_n = 1'b1;
      sweep_check("gshare", 1'b0);
      // Seven not-taken updates flush the global history back to zero so the
      // last prediction reads index 0x21 only if the hashed update wrote it.
      steps = '{st(1, 16'h2, 1, 16'h2, 0), st(1, 16'h4, 1, 16'h4, 0)};
      for (int k = 0; k < 7; k++) steps.push_back(st(1, 16'h0, 0, 16'h0, 0));
      steps.push_back(st(0, 16'h0, 0, 16'h4, GSHARE));
      foreach (steps[k]) begin
         drive(steps[k].uv, steps[k].upc, steps[k].ut, steps[k].ppc);
         exp_q.push_back(steps[k].exp);
         @(negedge clk);
         e = exp_q.pop_front();
         chk_cnt++;
         if (pred_taken !== e) $display("FAIL gshare[%0d]: pred_taken=%b expected %b", k, pred_taken, e);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_learning();
      test_sat_low();
      test_back_to_back();
      test_mid_reset();
      test_gshare();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
